mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/mem_stage_if.sv | 32 +++
 rtl/mem_stage.sv | 136 +++++++++++++
 tb/tb_mem_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used by the memory stage and its pipeline latches.
//   word_t      : 32-bit data/address word
//   regbits_t   : 5-bit register index
//   write_t     : writeback data source select (value 0 is the bubble encoding)
//   memstate_t  : memory-stage access FSM states
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    WR_ALU = 2'd0,
    WR_MEM = 2'd1,
    WR_NPC = 2'd2,
    WR_LUI = 2'd3
  } write_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } memstate_t;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline latch interfaces around the memory stage.
//   exec_mem_if : EX/MEM latch contents; ex drives, mem consumes.
//   mem_wb_if   : MEM/WB latch contents; mem drives, wb consumes.
interface exec_mem_if;
  import cpu_types_pkg::*;

  logic     dmemWEN;
  logic     dmemREN;
  logic     halt;
  word_t    alu_result;
  regbits_t wsel;
  write_t   wdat_source;
  word_t    instr_npc;
  word_t    dmemstore;

  modport ex  (output dmemWEN, dmemREN, halt, alu_result, wsel, wdat_source, instr_npc, dmemstore);
  modport mem (input  dmemWEN, dmemREN, halt, alu_result, wsel, wdat_source, instr_npc, dmemstore);
endinterface

interface mem_wb_if;
  import cpu_types_pkg::*;

  logic     halt;
  word_t    alu_result;
  word_t    dmemload;
  regbits_t wsel;
  write_t   wdat_source;
  word_t    instr_npc;

  modport mem (output halt, alu_result, dmemload, wsel, wdat_source, instr_npc);
  modport wb  (input  halt, alu_result, dmemload, wsel, wdat_source, instr_npc);
endinterface

// File: rtl/mem_stage.sv
// Memory stage: issues data-cache accesses for the entry in the EX/MEM latch,
// stalls the pipeline until the cache answers, and updates the MEM/WB latch.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   en, zero        pipeline advance enable / flush-to-bubble
//   in              EX/MEM latch (exec_mem_if.mem)
//   dmemREN/WEN     cache read / write request
//   dmemaddr/store  cache address / store data
//   dhit, dmemload  cache completion strobe / read data
//   mem_busy        stall request to the hazard unit
//   out             MEM/WB latch (mem_wb_if.mem)
//   stall_count     saturating count of cycles with mem_busy high
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             zero,
  exec_mem_if.mem          in,
  output logic             dmemREN,
  output logic             dmemWEN,
  output word_t            dmemaddr,
  output word_t            dmemstore,
  input  logic             dhit,
  input  word_t            dmemload,
  output logic             mem_busy,
  mem_wb_if.mem            out,
  output logic [CNT_W-1:0] stall_count
);

  memstate_t state, next_state;

  // Write wins when both request bits are set.
  logic req_wen, req_ren, req_any;
  assign req_wen = in.dmemWEN;
  assign req_ren = in.dmemREN & ~in.dmemWEN;
  assign req_any = req_wen | req_ren;

  // Request captured at issue so the cache sees a stable access even if the
  // EX/MEM latch is flushed while we wait.
  logic  hold_wen, hold_ren;
  word_t hold_addr, hold_store;
  word_t load_buf;
  logic  take_hit;

  always_comb begin
    next_state = state;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    dmemaddr   = in.alu_result;
    dmemstore  = in.dmemstore;
    mem_busy   = 1'b0;
    take_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          dmemREN    = req_ren;
          dmemWEN    = req_wen;
          mem_busy   = ~dhit;
          take_hit   = dhit;
          next_state = dhit ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        dmemREN   = hold_ren;
        dmemWEN   = hold_wen;
        dmemaddr  = hold_addr;
        dmemstore = hold_store;
        mem_busy  = ~dhit;
        take_hit  = dhit;
        if (dhit) next_state = DONE;
      end
      DONE: begin
        // Access already completed; wait for the entry to leave the stage.
        if (en) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (RST) begin
      dmemREN  = 1'b0;
      dmemWEN  = 1'b0;
      mem_busy = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      hold_wen    <= 1'b0;
      hold_ren    <= 1'b0;
      hold_addr   <= '0;
      hold_store  <= '0;
      load_buf    <= '0;
      stall_count <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && req_any) begin
        hold_wen   <= req_wen;
        hold_ren   <= req_ren;
        hold_addr  <= in.alu_result;
        hold_store <= in.dmemstore;
      end
      if (take_hit) load_buf <= dmemload;
      if (mem_busy && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end

  // MEM/WB latch. Flush beats a stall; halt survives flushes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out.halt        <= 1'b0;
      out.alu_result  <= '0;
      out.dmemload    <= '0;
      out.wsel        <= '0;
      out.wdat_source <= write_t'(0);
      out.instr_npc   <= '0;
    end else if (en && zero) begin
      out.alu_result  <= '0;
      out.dmemload    <= '0;
      out.wsel        <= '0;
      out.wdat_source <= write_t'(0);
      out.instr_npc   <= '0;
    end else if (en && !mem_busy) begin
      out.halt        <= out.halt | in.halt;
      out.alu_result  <= in.alu_result;
      out.dmemload    <= take_hit ? dmemload : load_buf;
      out.wsel        <= in.wsel;
      out.wdat_source <= in.wdat_source;
      out.instr_npc   <= in.instr_npc;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of pass-through vectors plus
// hand-written load/store/flush/reset/saturation sequences. Expected MEM/WB
// contents go through a scoreboard queue.
module tb_mem_stage;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic     halt;
    word_t    alu;
    word_t    ld;
    regbits_t wsel;
    write_t   ws;
    word_t    npc;
  } wb_t;

  typedef struct {
    logic     en, zero, halt;
    word_t    alu;
    regbits_t wsel;
    write_t   ws;
    word_t    npc;
    wb_t      exp;
  } vec_t;

  logic CLK = 1'b0, RST, en, zero, dhit, dhit4;
  word_t dmemload;
  logic dmemREN, dmemWEN, mem_busy, dmemREN4, dmemWEN4, mem_busy4;
  word_t dmemaddr, dmemstore, dmemaddr4, dmemstore4;
  logic [31:0] stall_count;
  logic [3:0]  stall_count4;

  exec_mem_if em();
  mem_wb_if   mw();
  exec_mem_if em4();
  mem_wb_if   mw4();

  mem_stage #(.CNT_W(32)) u_dut (
    .CLK(CLK), .RST(RST), .en(en), .zero(zero), .in(em),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .mem_busy(mem_busy), .out(mw),
    .stall_count(stall_count));

  mem_stage #(.CNT_W(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .en(en), .zero(zero), .in(em4),
    .dmemREN(dmemREN4), .dmemWEN(dmemWEN4), .dmemaddr(dmemaddr4), .dmemstore(dmemstore4),
    .dhit(dhit4), .dmemload(dmemload), .mem_busy(mem_busy4), .out(mw4),
    .stall_count(stall_count4));

  always #5 CLK = ~CLK;

  int errors = 0, checks = 0;
  wb_t sb[$];
  vec_t tbl[7];
  int wr, reiss;

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic wb_t cur();
    return {mw.halt, mw.alu_result, mw.dmemload, mw.wsel, mw.wdat_source, mw.instr_npc};
  endfunction

  function automatic wb_t W(logic h, word_t a, word_t l, regbits_t s, write_t w, word_t n);
    return {h, a, l, s, w, n};
  endfunction

  function automatic vec_t mkv(logic e, logic z, logic h, word_t a, regbits_t s,
                               write_t w, word_t n, wb_t x);
    vec_t v;
    v.en = e; v.zero = z; v.halt = h; v.alu = a; v.wsel = s; v.ws = w; v.npc = n; v.exp = x;
    return v;
  endfunction

  // Compare the MEM/WB latch against the oldest scoreboard entry.
  task automatic chk_sb(input string name);
    wb_t e, a;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      a = cur();
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, a, e);
      end
    end
  endtask

  task automatic set_em(logic wen, logic ren, logic h, word_t a, regbits_t s,
                        write_t w, word_t n, word_t st);
    em.dmemWEN = wen; em.dmemREN = ren; em.halt = h; em.alu_result = a;
    em.wsel = s; em.wdat_source = w; em.instr_npc = n; em.dmemstore = st;
  endtask

  initial begin
    RST = 1'b1; en = 1'b0; zero = 1'b0; dhit = 1'b0; dhit4 = 1'b0; dmemload = '0;
    set_em(0, 0, 0, 0, 0, WR_ALU, 0, 0);
    em4.dmemWEN = 0; em4.dmemREN = 0; em4.halt = 0; em4.alu_result = 0;
    em4.wsel = 0; em4.wdat_source = WR_ALU; em4.instr_npc = 0; em4.dmemstore = 0;
    step(); step();

    // Reset state
    chk("rst_out", 64'(cur() != '0), 64'(0));
    chk("rst_stall", 64'(stall_count), 64'(0));
    chk("rst_ren", 64'(dmemREN), 64'(0));
    chk("rst_wen", 64'(dmemWEN), 64'(0));
    RST = 1'b0;

    // Non-memory pass-through / hold / flush / sticky halt
    tbl[0] = mkv(1, 0, 0, 32'h55,       3,  WR_ALU, 32'h104, W(0, 32'h55, 0, 3, WR_ALU, 32'h104));
    tbl[1] = mkv(1, 0, 0, 32'hAAAA0001, 31, WR_NPC, 32'h200, W(0, 32'hAAAA0001, 0, 31, WR_NPC, 32'h200));
    tbl[2] = mkv(0, 0, 0, 32'h1234,     7,  WR_ALU, 32'h204, W(0, 32'hAAAA0001, 0, 31, WR_NPC, 32'h200));
    tbl[3] = mkv(1, 1, 0, 32'h9999,     9,  WR_MEM, 32'h208, W(0, 0, 0, 0, write_t'(0), 0));
    tbl[4] = mkv(1, 0, 0, 32'hFFFFFFFF, 1,  WR_LUI, 32'h300, W(0, 32'hFFFFFFFF, 0, 1, WR_LUI, 32'h300));
    tbl[5] = mkv(1, 0, 1, 32'h10,       2,  WR_ALU, 32'h304, W(1, 32'h10, 0, 2, WR_ALU, 32'h304));
    tbl[6] = mkv(1, 0, 0, 32'h20,       4,  WR_ALU, 32'h308, W(1, 32'h20, 0, 4, WR_ALU, 32'h308));
    for (int i = 0; i < 7; i++) begin
      en = tbl[i].en; zero = tbl[i].zero;
      set_em(0, 0, tbl[i].halt, tbl[i].alu, tbl[i].wsel, tbl[i].ws, tbl[i].npc, 0);
      #1;
      chk("vec_busy", 64'(mem_busy), 64'(0));
      sb.push_back(tbl[i].exp);
      step();
      chk_sb("vec_out");
    end

    // Clear sticky halt
    RST = 1'b1; en = 1'b0; zero = 1'b0; set_em(0, 0, 0, 0, 0, WR_ALU, 0, 0);
    step();
    RST = 1'b0;

    // Load 0x100, three wait cycles, then hit with 0xDEADBEEF
    en = 1'b1;
    set_em(0, 1, 0, 32'h100, 5, WR_MEM, 32'h400, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("ld_busy", 64'(mem_busy), 64'(1));
      chk("ld_ren", 64'(dmemREN), 64'(1));
      chk("ld_addr", 64'(dmemaddr), 64'(32'h100));
      step();
    end
    dhit = 1'b1; dmemload = 32'hDEADBEEF; #1;
    chk("ld_hit_busy", 64'(mem_busy), 64'(0));
    sb.push_back(W(0, 32'h100, 32'hDEADBEEF, 5, WR_MEM, 32'h400));
    step();
    chk_sb("ld_out");
    dhit = 1'b0; dmemload = '0;
    set_em(0, 0, 0, 32'h77, 2, WR_ALU, 32'h404, 0); #1;
    chk("ld_done_ren", 64'(dmemREN), 64'(0));
    chk("ld_stall_cnt", 64'(stall_count), 64'(3));
    sb.push_back(W(0, 32'h77, 32'hDEADBEEF, 2, WR_ALU, 32'h404));
    step();
    chk_sb("ld_buf_out");

    // Zero-wait hit in IDLE with both request bits set: write wins
    set_em(1, 1, 0, 32'h140, 6, WR_MEM, 32'h500, 32'hA5A5);
    dhit = 1'b1; dmemload = 32'h1111; #1;
    chk("prio_ren", 64'(dmemREN), 64'(0));
    chk("prio_wen", 64'(dmemWEN), 64'(1));
    chk("zw_busy", 64'(mem_busy), 64'(0));
    sb.push_back(W(0, 32'h140, 32'h1111, 6, WR_MEM, 32'h500));
    step();
    chk_sb("zw_out");
    dhit = 1'b0; dmemload = '0;
    set_em(0, 0, 0, 0, 0, WR_ALU, 32'h504, 0); #1;
    chk("zw_done_wen", 64'(dmemWEN), 64'(0));
    step();

    // Store 0x12345678 to 0x200, en low for 4 cycles after the hit
    en = 1'b0; wr = 0; reiss = 0;
    set_em(1, 0, 0, 32'h200, 0, WR_ALU, 32'h600, 32'h12345678); #1;
    chk("st_wen", 64'(dmemWEN), 64'(1));
    chk("st_addr", 64'(dmemaddr), 64'(32'h200));
    chk("st_data", 64'(dmemstore), 64'(32'h12345678));
    if (dmemWEN && dhit) wr++;
    step();
    dhit = 1'b1; #1;
    if (dmemWEN && dhit) wr++;
    step();
    dhit = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (dmemWEN) reiss++;
      step();
    end
    en = 1'b1; #1;
    if (dmemWEN) reiss++;
    sb.push_back(W(0, 32'h200, 0, 0, WR_ALU, 32'h600));
    step();
    chk_sb("st_out");
    set_em(0, 0, 0, 0, 0, WR_ALU, 0, 0);
    chk("st_writes", 64'(wr), 64'(1));
    chk("st_reissue", 64'(reiss), 64'(0));

    // Flush while a store is in ACCESS
    en = 1'b0; zero = 1'b0;
    set_em(1, 0, 0, 32'h300, 8, WR_ALU, 32'h700, 32'hCAFE);
    step();
    en = 1'b1; zero = 1'b1;
    set_em(0, 0, 0, 32'h999, 9, WR_ALU, 32'h999, 32'h999); #1;
    chk("fl_wen", 64'(dmemWEN), 64'(1));
    chk("fl_addr", 64'(dmemaddr), 64'(32'h300));
    chk("fl_data", 64'(dmemstore), 64'(32'hCAFE));
    chk("fl_busy", 64'(mem_busy), 64'(1));
    sb.push_back(W(0, 0, 0, 0, write_t'(0), 0));
    step();
    chk_sb("fl_bubble");
    en = 1'b0; zero = 1'b0; #1;
    chk("fl_wen_hold", 64'(dmemWEN), 64'(1));
    dhit = 1'b1;
    step();
    dhit = 1'b0; #1;
    chk("fl_done_wen", 64'(dmemWEN), 64'(0));
    en = 1'b1;
    step();

    // Reset in the middle of a store access
    en = 1'b0;
    set_em(1, 0, 0, 32'h400, 3, WR_ALU, 32'h800, 32'hBEEF);
    step(); #1;
    chk("rs_pre_wen", 64'(dmemWEN), 64'(1));
    RST = 1'b1;
    step();
    chk("rs_wen", 64'(dmemWEN), 64'(0));
    chk("rs_ren", 64'(dmemREN), 64'(0));
    chk("rs_busy", 64'(mem_busy), 64'(0));
    chk("rs_out", 64'(cur() != '0), 64'(0));
    chk("rs_stall", 64'(stall_count), 64'(0));
    chk("rs_state", 64'(u_dut.state), 64'(IDLE));
    set_em(0, 0, 0, 0, 0, WR_ALU, 0, 0);
    RST = 1'b0;
    step(); #1;
    chk("rs_after_wen", 64'(dmemWEN), 64'(0));

    // Stall counter saturation on the 4-bit instance (never hits)
    RST = 1'b1; em4.dmemREN = 1'b1;
    step(); step();
    RST = 1'b0;
    for (int c = 0; c < 14; c++) step();
    chk("sat_14", 64'(stall_count4), 64'(14));
    for (int c = 0; c < 4; c++) step();
    chk("sat_18", 64'(stall_count4), 64'(15));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
